video_timing_gen: RTL

Programmable raster timing generator: the transmit-side counterpart of the crop/aspect measurement stage. It produces the pixel clock enable and the DE/HS/VS stream that the measurement stage consumes. The measurement stage counts DE falling edges per frame, samples hsize on line 0, and treats the VS rising edge as frame start. It sits at the core's video output and drives test patterns or core pixel fetch via HCOUNT/VCOUNT. Timing fields are shadowed and take effect only at frame boundaries.

---
 rtl/video_timing_gen.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: pixel clock enable, DE/HS/VS and raster
// position, with the eight timing fields shadowed and applied only at frame start.
module video_timing_gen #(
   parameter int CE_DIV = 4
) (
   input  logic        CLK_VIDEO,
   input  logic        RESET,
   input  logic [11:0] H_ACTIVE,
   input  logic [11:0] H_FP,
   input  logic [11:0] H_SYNC,
   input  logic [11:0] H_BP,
   input  logic [11:0] V_ACTIVE,
   input  logic [11:0] V_FP,
   input  logic [11:0] V_SYNC,
   input  logic [11:0] V_BP,
   output logic        CE_PIXEL,
   output logic        VGA_DE,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic [11:0] HCOUNT,
   output logic [11:0] VCOUNT,
   output logic        FRAME_START
);

   localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   function automatic logic [13:0] total4(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] c, input logic [11:0] d);
      return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
   endfunction

   function automatic logic cfg_valid(input logic [11:0] ha, input logic [11:0] va,
                                      input logic [13:0] htot, input logic [13:0] vtot);
      return (ha != 12'd0) && (va != 12'd0) && (htot <= 14'd4096) && (vtot <= 14'd4096);
   endfunction

   // An empty window (len == 0) never matches, so a zero sync width disables sync.
   function automatic logic in_window(input logic [11:0] pos, input logic [13:0] start,
                                      input logic [11:0] len);
      logic [13:0] p;
      p = {2'b00, pos};
      return (p >= start) && (p < (start + {2'b00, len}));
   endfunction

   logic [3:0]  div_r;
   logic        ce_r;
   state_t      state_r, state_s;
   logic [11:0] h_r, v_r, h_s, v_s;
   logic        de_r, hs_r, vs_r, fs_r;
   logic        latch_s, fs_s, run_s, de_s, hs_s, vs_s;

   logic [11:0] ha_r, hfp_r, hsy_r, hbp_r, va_r, vfp_r, vsy_r, vbp_r;
   logic [11:0] dec_ha_s, dec_hfp_s, dec_hsy_s, dec_va_s, dec_vfp_s, dec_vsy_s;
   logic [13:0] in_htot_s, in_vtot_s, sh_htot_s, sh_vtot_s;
   logic        in_valid_s, h_end_s, v_end_s;

   assign in_htot_s  = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
   assign in_vtot_s  = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);
   assign in_valid_s = cfg_valid(H_ACTIVE, V_ACTIVE, in_htot_s, in_vtot_s);
   assign sh_htot_s  = total4(ha_r, hfp_r, hsy_r, hbp_r);
   assign sh_vtot_s  = total4(va_r, vfp_r, vsy_r, vbp_r);
   assign h_end_s    = ({2'b00, h_r} == (sh_htot_s - 14'd1));
   assign v_end_s    = ({2'b00, v_r} == (sh_vtot_s - 14'd1));

   // Pixel clock divider and registered enable
   always_ff @(posedge CLK_VIDEO or posedge RESET) begin
      if (RESET) begin
         div_r <= 4'd0;
         ce_r  <= 1'b0;
      end else begin
         ce_r <= (div_r == DIV_LAST);
         if (div_r == DIV_LAST) begin
            div_r <= 4'd0;
         end else begin
            div_r <= div_r + 4'd1;
         end
      end
   end

   // Next raster position, state and frame-boundary config latch
   always_comb begin
      state_s = state_r;
      h_s     = h_r;
      v_s     = v_r;
      latch_s = 1'b0;
      fs_s    = 1'b0;
      if (ce_r) begin
         case (state_r)
            ST_IDLE, ST_HOLD: begin
               latch_s = 1'b1;
               h_s     = 12'd0;
               v_s     = 12'd0;
               if (in_valid_s) begin
                  state_s = ST_RUN;
                  fs_s    = 1'b1;
               end else begin
                  state_s = ST_HOLD;
               end
            end
            ST_RUN: begin
               if (h_end_s) begin
                  h_s = 12'd0;
                  if (v_end_s) begin
                     v_s     = 12'd0;
                     latch_s = 1'b1;
                     if (in_valid_s) begin
                        fs_s = 1'b1;
                     end else begin
                        state_s = ST_HOLD;
                     end
                  end else begin
                     v_s = v_r + 12'd1;
                  end
               end else begin
                  h_s = h_r + 12'd1;
               end
            end
            default: begin
               state_s = ST_IDLE;
               h_s     = 12'd0;
               v_s     = 12'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Decode uses the config that will be in force after this edge
   always_comb begin
      if (latch_s) begin
         dec_ha_s  = H_ACTIVE;
         dec_hfp_s = H_FP;
         dec_hsy_s = H_SYNC;
         dec_va_s  = V_ACTIVE;
         dec_vfp_s = V_FP;
         dec_vsy_s = V_SYNC;
      end else begin
         dec_ha_s  = ha_r;
         dec_hfp_s = hfp_r;
         dec_hsy_s = hsy_r;
         dec_va_s  = va_r;
         dec_vfp_s = vfp_r;
         dec_vsy_s = vsy_r;
      end
   end

   assign run_s = (state_s == ST_RUN);
   assign de_s  = run_s && (h_s < dec_ha_s) && (v_s < dec_va_s);
   assign hs_s  = run_s && in_window(h_s, {2'b00, dec_ha_s} + {2'b00, dec_hfp_s}, dec_hsy_s);
   assign vs_s  = run_s && in_window(v_s, {2'b00, dec_va_s} + {2'b00, dec_vfp_s}, dec_vsy_s);

   // State, position and decoded outputs registered together so they never skew
   always_ff @(posedge CLK_VIDEO or posedge RESET) begin
      if (RESET) begin
         state_r <= ST_IDLE;
         h_r     <= 12'd0;
         v_r     <= 12'd0;
         de_r    <= 1'b0;
         hs_r    <= 1'b0;
         vs_r    <= 1'b0;
         fs_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         h_r     <= h_s;
         v_r     <= v_s;
         de_r    <= de_s;
         hs_r    <= hs_s;
         vs_r    <= vs_s;
         fs_r    <= fs_s;
      end
   end

   // Shadow timing fields
   always_ff @(posedge CLK_VIDEO or posedge RESET) begin
      if (RESET) begin
         ha_r  <= 12'd0;
         hfp_r <= 12'd0;
         hsy_r <= 12'd0;
         hbp_r <= 12'd0;
         va_r  <= 12'd0;
         vfp_r <= 12'd0;
         vsy_r <= 12'd0;
         vbp_r <= 12'd0;
      end else if (latch_s) begin
         ha_r  <= H_ACTIVE;
         hfp_r <= H_FP;
         hsy_r <= H_SYNC;
         hbp_r <= H_BP;
         va_r  <= V_ACTIVE;
         vfp_r <= V_FP;
         vsy_r <= V_SYNC;
         vbp_r <= V_BP;
      end else begin
         ha_r  <= ha_r;
         hfp_r <= hfp_r;
         hsy_r <= hsy_r;
         hbp_r <= hbp_r;
         va_r  <= va_r;
         vfp_r <= vfp_r;
         vsy_r <= vsy_r;
         vbp_r <= vbp_r;
      end
   end

   assign CE_PIXEL    = ce_r;
   assign VGA_DE      = de_r;
   assign VGA_HS      = hs_r;
   assign VGA_VS      = vs_r;
   assign HCOUNT      = h_r;
   assign VCOUNT      = v_r;
   assign FRAME_START = fs_r;

endmodule
